// File: rtl/memory_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage.
package memory_stage_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    localparam int unsigned DataWDefault = 8;
    localparam int unsigned RdWDefault   = 3;
    localparam int unsigned CntW         = 8;

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter for an outstanding data-memory access; expired flags the last allowed cycle.
module mem_timeout_counter
    import memory_stage_pkg::*;
#(
    parameter int unsigned CNT_W   = CntW,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count is 0 in the first request cycle, so TIMEOUT-1 marks request cycle TIMEOUT.
    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_stage.sv
// MEM stage: ALU results pass through in one cycle; loads/stores run a req/ack
// transaction, stalling upstream, and abort with a fault pulse on timeout.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DataWDefault,
    parameter int unsigned RD_W    = RdWDefault,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] write_data_wb,
    output logic [RD_W-1:0]   rd_wb,
    output logic              reg_write_wb,
    output logic              mem_fault,
    output logic [DATA_W-1:0] fault_addr
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [RD_W-1:0]     rd_lat_q, rd_lat_d;
    logic                rw_lat_q, rw_lat_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [RD_W-1:0]     rd_wb_q, rd_wb_d;
    logic                rw_wb_q, rw_wb_d;
    logic                fault_q, fault_d;
    logic [DATA_W-1:0]   fault_addr_q, fault_addr_d;

    logic cnt_clear;
    logic cnt_en;
    logic expired;

    mem_timeout_counter #(
        .CNT_W   (CntW),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rd_lat_d     = rd_lat_q;
        rw_lat_d     = rw_lat_q;
        wb_data_d    = wb_data_q;
        rd_wb_d      = rd_wb_q;
        rw_wb_d      = rw_wb_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        stall        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!in_valid) begin
                    rw_wb_d = 1'b0;
                end else if (in_mem_read || in_mem_write) begin
                    stall     = 1'b1;
                    addr_d    = in_alu_result;
                    wdata_d   = in_store_data;
                    we_d      = in_mem_write;
                    rd_lat_d  = in_rd;
                    rw_lat_d  = in_reg_write;
                    rw_wb_d   = 1'b0;
                    cnt_clear = 1'b1;
                    state_d   = StAccess;
                end else begin
                    wb_data_d = in_alu_result;
                    rd_wb_d   = in_rd;
                    rw_wb_d   = in_reg_write;
                end
            end
            StAccess: begin
                cnt_en  = 1'b1;
                rw_wb_d = 1'b0;
                // Ack beats a coincident timeout.
                if (dmem_ack) begin
                    if (!we_q) begin
                        wb_data_d = dmem_rdata;
                        rd_wb_d   = rd_lat_q;
                        rw_wb_d   = rw_lat_q;
                    end
                    state_d = StIdle;
                end else if (expired) begin
                    fault_d      = 1'b1;
                    fault_addr_d = addr_q;
                    state_d      = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            rd_lat_q     <= '0;
            rw_lat_q     <= 1'b0;
            wb_data_q    <= '0;
            rd_wb_q      <= '0;
            rw_wb_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            rd_lat_q     <= rd_lat_d;
            rw_lat_q     <= rw_lat_d;
            wb_data_q    <= wb_data_d;
            rd_wb_q      <= rd_wb_d;
            rw_wb_q      <= rw_wb_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign dmem_req      = (state_q == StAccess);
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign write_data_wb = wb_data_q;
    assign rd_wb         = rd_wb_q;
    assign reg_write_wb  = rw_wb_q;
    assign mem_fault     = fault_q;
    assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios then random instruction stream,
// checked against a per-instruction timeline model.
module tb_memory_stage;

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 3;
    localparam int unsigned TO = 4;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_mem_read;
    logic          in_mem_write;
    logic          in_reg_write;
    logic [RW-1:0] in_rd;
    logic [DW-1:0] in_alu_result;
    logic [DW-1:0] in_store_data;
    logic          stall;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;
    logic [DW-1:0] write_data_wb;
    logic [RW-1:0] rd_wb;
    logic          reg_write_wb;
    logic          mem_fault;
    logic [DW-1:0] fault_addr;

    memory_stage #(
        .DATA_W  (DW),
        .RD_W    (RW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_reg_write  (in_reg_write),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .write_data_wb (write_data_wb),
        .rd_wb         (rd_wb),
        .reg_write_wb  (reg_write_wb),
        .mem_fault     (mem_fault),
        .fault_addr    (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural view of the MEM/WB register and fault log.
    logic [DW-1:0] m_wdb;
    logic [RW-1:0] m_rd;
    logic [DW-1:0] m_fault_addr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_inputs();
        in_valid      = 1'($urandom);
        in_mem_read   = 1'($urandom);
        in_mem_write  = 1'($urandom);
        in_reg_write  = 1'($urandom);
        in_rd         = 3'($urandom);
        in_alu_result = 8'($urandom);
        in_store_data = 8'($urandom);
    endtask

    task automatic check_wb(input string tag, input logic exp_rw);
        check_eq({tag, "_wdb"}, 32'(write_data_wb), 32'(m_wdb));
        check_eq({tag, "_rd"}, 32'(rd_wb), 32'(m_rd));
        check_eq({tag, "_rw"}, 32'(reg_write_wb), 32'(exp_rw));
        check_eq({tag, "_faddr"}, 32'(fault_addr), 32'(m_fault_addr));
    endtask

    task automatic do_bubble();
        garbage_inputs();
        in_valid   = 1'b0;
        dmem_ack   = 1'($urandom);
        dmem_rdata = 8'($urandom);
        #1;
        check_eq("bub_stall", 32'(stall), 0);
        check_eq("bub_req", 32'(dmem_req), 0);
        next_cycle();
        dmem_ack = 1'b0;
        check_wb("bub", 1'b0);
        check_eq("bub_fault", 32'(mem_fault), 0);
    endtask

    task automatic do_alu(input logic [DW-1:0] res, input logic [RW-1:0] rd, input logic rw);
        in_valid      = 1'b1;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_reg_write  = rw;
        in_rd         = rd;
        in_alu_result = res;
        in_store_data = 8'($urandom);
        dmem_ack      = 1'($urandom);
        dmem_rdata    = 8'($urandom);
        #1;
        check_eq("alu_stall", 32'(stall), 0);
        check_eq("alu_req", 32'(dmem_req), 0);
        next_cycle();
        dmem_ack = 1'b0;
        in_valid = 1'b0;
        m_wdb    = res;
        m_rd     = rd;
        check_wb("alu", rw);
        check_eq("alu_fault", 32'(mem_fault), 0);
    endtask

    // k in 1..TO: ack arrives in request cycle k; otherwise the access times out.
    task automatic do_mem(input logic rd_en, input logic wr_en, input logic [DW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [RW-1:0] rd, input logic rw,
                          input logic [DW-1:0] rdata, input int k);
        bit acked = 0;
        bit exp_stall;
        in_valid      = 1'b1;
        in_mem_read   = rd_en;
        in_mem_write  = wr_en;
        in_reg_write  = rw;
        in_rd         = rd;
        in_alu_result = addr;
        in_store_data = wdata;
        dmem_ack      = 1'($urandom);
        dmem_rdata    = 8'($urandom);
        #1;
        check_eq("mem_c0_stall", 32'(stall), 1);
        check_eq("mem_c0_req", 32'(dmem_req), 0);
        next_cycle();
        for (int j = 1; j <= int'(TO); j++) begin
            garbage_inputs();
            dmem_ack   = (j == k);
            dmem_rdata = (j == k) ? rdata : 8'($urandom);
            exp_stall  = (j != k) && (j != int'(TO));
            #1;
            check_eq("mem_req", 32'(dmem_req), 1);
            check_eq("mem_addr", 32'(dmem_addr), 32'(addr));
            check_eq("mem_we", 32'(dmem_we), 32'(wr_en));
            check_eq("mem_wdata", 32'(dmem_wdata), 32'(wdata));
            check_eq("mem_rw_hold", 32'(reg_write_wb), 0);
            check_eq("mem_fault_low", 32'(mem_fault), 0);
            check_eq("mem_stall", 32'(stall), 32'(exp_stall));
            next_cycle();
            dmem_ack = 1'b0;
            if (j == k) begin
                acked = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (acked) begin
            if (!wr_en) begin
                m_wdb = rdata;
                m_rd  = rd;
                check_wb("ld_done", rw);
            end else begin
                check_wb("st_done", 1'b0);
            end
            check_eq("done_fault", 32'(mem_fault), 0);
        end else begin
            m_fault_addr = addr;
            check_wb("to_done", 1'b0);
            check_eq("to_fault", 32'(mem_fault), 1);
        end
        check_eq("done_req", 32'(dmem_req), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0;
        in_rd = '0; in_alu_result = '0; in_store_data = '0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        m_wdb = '0; m_rd = '0; m_fault_addr = '0;
        next_cycle();
        next_cycle();
        check_eq("rst_req", 32'(dmem_req), 0);
        check_eq("rst_stall", 32'(stall), 0);
        check_eq("rst_fault", 32'(mem_fault), 0);
        check_eq("rst_addr", 32'(dmem_addr), 0);
        check_wb("rst", 1'b0);
        reset_n = 1'b1;
        next_cycle();

        do_alu(8'h2A, 3'd3, 1'b1);
        do_mem(1'b1, 1'b0, 8'h10, 8'h00, 3'd5, 1'b1, 8'h5C, 3);
        do_mem(1'b0, 1'b1, 8'h80, 8'hF0, 3'd1, 1'b1, 8'h00, 1);
        do_alu(8'h77, 3'd6, 1'b1);
        do_mem(1'b1, 1'b0, 8'h33, 8'h00, 3'd2, 1'b1, 8'h00, 0);
        do_bubble();
        do_mem(1'b1, 1'b0, 8'h33, 8'h00, 3'd2, 1'b1, 8'hA5, int'(TO));
        do_mem(1'b1, 1'b1, 8'h44, 8'h12, 3'd4, 1'b1, 8'h99, 2);
        do_mem(1'b1, 1'b0, 8'h20, 8'h00, 3'd2, 1'b1, 8'h3C, 2);
        do_alu(8'h3D, 3'd2, 1'b1);

        // Reset in cycle 2 of a load.
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
        in_reg_write = 1'b1; in_rd = 3'd7; in_alu_result = 8'h55;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        reset_n = 1'b0;
        #1;
        m_wdb = '0; m_rd = '0; m_fault_addr = '0;
        check_eq("mrst_req", 32'(dmem_req), 0);
        check_eq("mrst_stall", 32'(stall), 0);
        check_eq("mrst_fault", 32'(mem_fault), 0);
        check_eq("mrst_addr", 32'(dmem_addr), 0);
        check_wb("mrst", 1'b0);
        next_cycle();
        reset_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 8'hEE;
        next_cycle();
        dmem_ack = 1'b0;
        check_eq("late_ack_req", 32'(dmem_req), 0);
        check_eq("late_ack_fault", 32'(mem_fault), 0);
        check_wb("late_ack", 1'b0);

        for (int n = 0; n < 300; n++) begin
            int sel = int'($urandom_range(0, 9));
            if (sel < 2) begin
                do_bubble();
            end else if (sel < 5) begin
                do_alu(8'($urandom), 3'($urandom), 1'($urandom));
            end else begin
                logic r = (sel != 7);
                logic w = (sel >= 7);
                do_mem(r, w, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
                       8'($urandom), int'($urandom_range(0, TO + 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the 8-bit core; consumes the registered ALU result from the execute stage and produces the MEM/WB register whose `write_data_wb` feeds back into execute's forwarding mux. Non-memory instructions pass through in one cycle. Loads and stores run a req/ack transaction on the data-memory port, stall the upstream pipeline until completion, and abort with a fault pulse if the memory does not answer within `TIMEOUT` cycles.

## Interface
- `DATA_W`, 8, data and address width
- `RD_W`, 3, destination register index width
- `TIMEOUT`, 15, max cycles in ACCESS without ack before abort (1..255)
- `clk` in 1 — clock, rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — EX/MEM register holds a live instruction
- `in_mem_read` in 1 — instruction is a load
- `in_mem_write` in 1 — instruction is a store
- `in_reg_write` in 1 — instruction writes `in_rd`
- `in_rd` in RD_W — destination register
- `in_alu_result` in DATA_W — ALU result / memory address
- `in_store_data` in DATA_W — store data (forwarded reg2)
- `stall` out 1 — freeze PC, IF/ID, ID/EX, EX/MEM this cycle (combinational)
- `dmem_req` out 1 — memory request, held until ack/abort
- `dmem_we` out 1 — 1 store, 0 load
- `dmem_addr` out DATA_W — latched address
- `dmem_wdata` out DATA_W — latched store data
- `dmem_rdata` in DATA_W — load data, valid with `dmem_ack`
- `dmem_ack` in 1 — one-cycle completion strobe
- `write_data_wb` out DATA_W — MEM/WB result, forwarding source
- `rd_wb` out RD_W — MEM/WB destination
- `reg_write_wb` out 1 — MEM/WB write enable
- `mem_fault` out 1 — one-cycle pulse on timeout abort
- `fault_addr` out DATA_W — address of last aborted access (sticky)

## Operation
- States: IDLE, ACCESS. Reset: IDLE; all outputs and latches 0.
- IDLE, `in_valid=0`: bubble — `reg_write_wb<=0`, `write_data_wb`/`rd_wb` hold.
- IDLE, valid, no mem op: `write_data_wb<=in_alu_result`, `rd_wb<=in_rd`, `reg_write_wb<=in_reg_write`; `stall=0`.
- IDLE, valid, `in_mem_read|in_mem_write`: `stall=1`; latch addr, wdata, rd, reg_write, `we=in_mem_write`; clear counter; `reg_write_wb<=0`; → ACCESS.
- Both read and write set: treated as store; no writeback.
- ACCESS: `dmem_req=1`, addr/wdata/we from latches, stable; counter increments each cycle; `reg_write_wb<=0` every non-completing cycle; `in_*` ignored.
- ACCESS, `dmem_ack`: load → `write_data_wb<=dmem_rdata`, `rd_wb<=latched rd`, `reg_write_wb<=latched reg_write`; store → `reg_write_wb<=0`. `stall=0` this cycle; → IDLE.
- ACCESS, no ack, counter reaches TIMEOUT: `mem_fault<=1` for one cycle, `fault_addr<=latched addr`, `reg_write_wb<=0`; `stall=0`; → IDLE.
- Ack and timeout in same cycle: ack wins, no fault.
- `dmem_ack` outside ACCESS: ignored.
- `stall = (IDLE & in_valid & memop) | (ACCESS & ~dmem_ack & ~timeout)`.

## Timing
- Non-memory: result on `write_data_wb` one edge after accept.
- Memory: accept cycle 0 (stall high, no req); `dmem_req` high from cycle 1; ack in cycle k ≥ 1 → result/`reg_write_wb` visible cycle k+1; stall high cycles 0..k-1.
- Timeout: req high cycles 1..TIMEOUT; abort decided in cycle TIMEOUT; `mem_fault` high cycle TIMEOUT+1.
- Upstream advances on the edge ending the first `stall=0` cycle; next instruction presented the following cycle, never double-accepted.
- `reset_n` low mid-access: `dmem_req`, `stall`, `reg_write_wb` drop immediately; no writeback, no fault.
- `dmem_req` never deasserts in ACCESS before ack/abort; addr/wdata/we never change while `dmem_req=1`.

## Structure
- `memory_stage_pkg`: state enum {IDLE, ACCESS}, `DATA_W`/`RD_W` defaults, timeout counter width (8).
- One sub-module: `mem_timeout_counter` (clear, enable, terminal count = TIMEOUT, `expired` output).

## Test plan
- Pass-through: valid ADD, `in_alu_result=8'h2A`, rd=3, reg_write=1 → next cycle `write_data_wb=8'h2A`, `rd_wb=3`, `reg_write_wb=1`, stall never high.
- Load, ack after 3 cycles with `dmem_rdata=8'h5C`, addr 8'h10 → `dmem_addr=8'h10`, `dmem_we=0`, req cycles 1–3, stall cycles 0–2, cycle 4 `write_data_wb=8'h5C`, `reg_write_wb=1`.
- Store addr 8'h80 data 8'hF0, ack cycle 1 → `dmem_we=1`, `dmem_wdata=8'hF0`, `reg_write_wb=0` throughout; next instruction accepted cycle 2.
- Timeout (TIMEOUT=4), load addr 8'h33, no ack → req cycles 1–4, `mem_fault` pulse cycle 5, `fault_addr=8'h33`, no writeback; ack in cycle 4 instead → completes, no fault.
- Back-to-back load then ALU op with rd matching → load result on `write_data_wb` one cycle before ALU result; ALU op not lost or duplicated.
- `reset_n` low in cycle 2 of a load → `dmem_req=0` immediately, outputs 0, IDLE after release; late `dmem_ack` ignored.
